// File: rtl/max_pool_1_addr_gen.sv
// Window address generator for the 2x2/stride-2 max-pool core.
// Walks ch/orow/ocol/dy/dx and streams row_idx*W + col through a 3-stage pipe.
module max_pool_1_addr_gen #(
    parameter int ROW_W  = 11,
    parameter int WID_W  = 5,
    parameter int CH_W   = 6,
    parameter int ADDR_W = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [WID_W-1:0]  cfg_width,
    input  logic [WID_W-1:0]  cfg_height,
    input  logic [CH_W-1:0]   cfg_chan,
    output logic [ADDR_W-1:0] addr_data,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              addr_win_last,
    output logic              addr_last
);

    localparam int OW_W = WID_W - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WID_W-1:0] w_q, w_d, h_q, h_d;
    logic [CH_W-1:0]  c_q, c_d;
    logic [OW_W-1:0]  ow_q, ow_d, oh_q, oh_d;

    logic [CH_W-1:0]  ch_q, ch_d;
    logic [OW_W-1:0]  orow_q, orow_d, ocol_q, ocol_d;
    logic             dy_q, dy_d, dx_q, dx_d;
    logic [ROW_W-1:0] base_q, base_d;

    logic              s0_vld_q, s0_wl_q, s0_last_q;
    logic [ROW_W-1:0]  s0_row_q;
    logic [WID_W-1:0]  s0_col_q;
    logic              s1_vld_q, s1_wl_q, s1_last_q;
    logic [ADDR_W-1:0] s1_prod_q;
    logic [WID_W-1:0]  s1_col_q;
    logic              s2_vld_q, s2_wl_q, s2_last_q;
    logic [ADDR_W-1:0] s2_addr_q;

    logic             en, degen, load_cfg, step;
    logic             ocol_end, orow_end, ch_end, win_end, cnt_last;
    logic [ROW_W-1:0] cur_row;
    logic [WID_W-1:0] cur_col;

    assign en    = !s2_vld_q || addr_ready;
    assign degen = (cfg_width[WID_W-1:1] == '0)
                || (cfg_height[WID_W-1:1] == '0)
                || (cfg_chan == '0);

    assign win_end  = dy_q && dx_q;
    assign ocol_end = (ocol_q == ow_q - OW_W'(1));
    assign orow_end = (orow_q == oh_q - OW_W'(1));
    assign ch_end   = (ch_q == c_q - CH_W'(1));
    assign cnt_last = win_end && ocol_end && orow_end && ch_end;

    assign cur_row = base_q + ROW_W'({orow_q, dy_q});
    assign cur_col = {ocol_q, dx_q};

    always_comb begin
        state_d  = state_q;
        load_cfg = 1'b0;
        step     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    if (degen) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_RUN;
                        load_cfg = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (en) begin
                    step = 1'b1;
                    if (cnt_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (s2_vld_q && addr_ready && s2_last_q) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Counter nest: dx fastest, then dy, ocol, orow, channel (base += H).
    always_comb begin
        w_d    = w_q;
        h_d    = h_q;
        c_d    = c_q;
        ow_d   = ow_q;
        oh_d   = oh_q;
        ch_d   = ch_q;
        orow_d = orow_q;
        ocol_d = ocol_q;
        dy_d   = dy_q;
        dx_d   = dx_q;
        base_d = base_q;
        if (load_cfg) begin
            w_d    = cfg_width;
            h_d    = cfg_height;
            c_d    = cfg_chan;
            ow_d   = cfg_width[WID_W-1:1];
            oh_d   = cfg_height[WID_W-1:1];
            ch_d   = '0;
            orow_d = '0;
            ocol_d = '0;
            dy_d   = 1'b0;
            dx_d   = 1'b0;
            base_d = '0;
        end else if (step) begin
            dx_d = !dx_q;
            if (dx_q) begin
                dy_d = !dy_q;
                if (dy_q) begin
                    if (ocol_end) begin
                        ocol_d = '0;
                        if (orow_end) begin
                            orow_d = '0;
                            ch_d   = ch_q + CH_W'(1);
                            base_d = base_q + ROW_W'(h_q);
                        end else begin
                            orow_d = orow_q + OW_W'(1);
                        end
                    end else begin
                        ocol_d = ocol_q + OW_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            h_q     <= '0;
            c_q     <= '0;
            ow_q    <= '0;
            oh_q    <= '0;
            ch_q    <= '0;
            orow_q  <= '0;
            ocol_q  <= '0;
            dy_q    <= 1'b0;
            dx_q    <= 1'b0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            c_q     <= c_d;
            ow_q    <= ow_d;
            oh_q    <= oh_d;
            ch_q    <= ch_d;
            orow_q  <= orow_d;
            ocol_q  <= ocol_d;
            dy_q    <= dy_d;
            dx_q    <= dx_d;
            base_q  <= base_d;
        end
    end

    // One global enable: the whole pipe freezes while the output is stalled.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s0_vld_q  <= 1'b0;
            s0_wl_q   <= 1'b0;
            s0_last_q <= 1'b0;
            s0_row_q  <= '0;
            s0_col_q  <= '0;
            s1_vld_q  <= 1'b0;
            s1_wl_q   <= 1'b0;
            s1_last_q <= 1'b0;
            s1_prod_q <= '0;
            s1_col_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_wl_q   <= 1'b0;
            s2_last_q <= 1'b0;
            s2_addr_q <= '0;
        end else if (en) begin
            s0_vld_q  <= step;
            s0_wl_q   <= step && win_end;
            s0_last_q <= step && cnt_last;
            s0_row_q  <= cur_row;
            s0_col_q  <= cur_col;
            s1_vld_q  <= s0_vld_q;
            s1_wl_q   <= s0_wl_q;
            s1_last_q <= s0_last_q;
            s1_prod_q <= ADDR_W'(s0_row_q) * ADDR_W'(w_q);
            s1_col_q  <= s0_col_q;
            s2_vld_q  <= s1_vld_q;
            s2_wl_q   <= s1_wl_q;
            s2_last_q <= s1_last_q;
            s2_addr_q <= s1_prod_q + ADDR_W'(s1_col_q);
        end
    end

    assign addr_valid    = s2_vld_q;
    assign addr_data     = s2_addr_q;
    assign addr_win_last = s2_wl_q;
    assign addr_last     = s2_last_q;
    assign ap_done       = (state_q == S_DONE);
    assign ap_ready      = ap_done;
    assign ap_idle       = (state_q == S_IDLE);

endmodule

// File: tb/tb_max_pool_1_addr_gen.sv
// Directed bench for max_pool_1_addr_gen: job table, stall pattern,
// degenerate configs and mid-job reset.
module tb_max_pool_1_addr_gen;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [4:0]  cfg_width, cfg_height;
    logic [5:0]  cfg_chan;
    logic [15:0] addr_data;
    logic        addr_valid, addr_ready, addr_win_last, addr_last;

    max_pool_1_addr_gen dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .ap_start     (ap_start),
        .ap_done      (ap_done),
        .ap_idle      (ap_idle),
        .ap_ready     (ap_ready),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .cfg_chan     (cfg_chan),
        .addr_data    (addr_data),
        .addr_valid   (addr_valid),
        .addr_ready   (addr_ready),
        .addr_win_last(addr_win_last),
        .addr_last    (addr_last)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int w;
        int h;
        int c;
        int mode;
        int beats;
        int lastaddr;
        bit lat;
    } vec_t;

    vec_t tbl[8];
    int   exp44[16];
    int   exp55[16];
    int   eq_a[$];
    bit   eq_w[$];
    bit   eq_l[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic build(input int w, input int h, input int c);
        int oh, ow;
        eq_a.delete();
        eq_w.delete();
        eq_l.delete();
        oh = h / 2;
        ow = w / 2;
        for (int ch = 0; ch < c; ch++)
            for (int r = 0; r < oh; r++)
                for (int q = 0; q < ow; q++)
                    for (int dy = 0; dy < 2; dy++)
                        for (int dx = 0; dx < 2; dx++) begin
                            eq_a.push_back((ch*h + 2*r + dy)*w + 2*q + dx);
                            eq_w.push_back(dy == 1 && dx == 1);
                            eq_l.push_back(0);
                        end
        if (eq_l.size() > 0) eq_l[eq_l.size()-1] = 1;
        if (w == 4 && h == 4 && c == 1)
            for (int i = 0; i < 16; i++) eq_a[i] = exp44[i];
        if (w == 5 && h == 5 && c == 1)
            for (int i = 0; i < 16; i++) eq_a[i] = exp55[i];
    endtask

    task automatic run_job(input vec_t v);
        int nb, done_t, first_t, last_t, last_seen, prev_d, budget;
        bit prev_stall;
        build(v.w, v.h, v.c);
        nb = 0; done_t = -1; first_t = -1; last_t = -1;
        last_seen = -1; prev_d = 0; prev_stall = 0;
        budget = 2*v.beats + 40;
        @(negedge ap_clk);
        chk("idle_before_start", ap_idle, 1);
        cfg_width  = 5'(v.w);
        cfg_height = 5'(v.h);
        cfg_chan   = 6'(v.c);
        ap_start   = 1'b1;
        addr_ready = 1'b1;
        for (int t = 1; t <= budget && done_t < 0; t++) begin
            @(negedge ap_clk);
            ap_start = 1'b0;
            if (t == 8 && v.beats >= 16) begin
                ap_start  = 1'b1;
                cfg_width = cfg_width ^ 5'h3;
                cfg_chan  = cfg_chan + 6'd1;
            end
            if (v.mode == 0) addr_ready = 1'b1;
            else addr_ready = (t >= 10 && t < 15) ? 1'b0 : (t % 2 == 1);
            if (prev_stall) begin
                chk("stall_valid_hold", addr_valid, 1);
                chk("stall_data_hold", addr_data, prev_d);
            end
            if (addr_valid) begin
                if (first_t < 0) first_t = t;
                if (addr_ready) begin
                    if (nb < eq_a.size()) begin
                        chk($sformatf("addr[%0d]", nb), addr_data, eq_a[nb]);
                        chk($sformatf("win_last[%0d]", nb), addr_win_last, eq_w[nb]);
                        chk($sformatf("last[%0d]", nb), addr_last, eq_l[nb]);
                    end else begin
                        chk("extra_beat", nb, eq_a.size());
                    end
                    nb++;
                    last_t = t;
                    last_seen = addr_data;
                end
            end
            prev_stall = addr_valid && !addr_ready;
            prev_d = addr_data;
            if (ap_done) begin
                done_t = t;
                chk("ap_ready_eq_done", ap_ready, 1);
            end
        end
        ap_start = 1'b0;
        chk("beat_count", nb, v.beats);
        chk("done_seen", done_t >= 0, 1);
        if (v.beats > 0) begin
            chk("final_addr", last_seen, v.lastaddr);
            if (v.mode == 0) chk("done_after_last", done_t, last_t + 1);
            if (v.lat) chk("first_valid_latency", first_t, 4);
        end else begin
            chk("degen_no_valid", first_t, -1);
            chk("degen_done_quick", done_t >= 1 && done_t <= 2, 1);
        end
        @(negedge ap_clk);
        chk("idle_after", ap_idle, 1);
        chk("done_one_cycle", ap_done, 0);
    endtask

    task automatic reset_mid_job();
        int nb;
        bit any_done;
        vec_t v;
        nb = 0;
        @(negedge ap_clk);
        cfg_width = 5'd4; cfg_height = 5'd4; cfg_chan = 6'd1;
        ap_start = 1'b1; addr_ready = 1'b1;
        for (int t = 1; t <= 40 && nb < 6; t++) begin
            @(negedge ap_clk);
            ap_start = 1'b0;
            if (addr_valid) nb++;
        end
        chk("reset_test_six_beats", nb, 6);
        @(negedge ap_clk);
        ap_rst = 1'b1;
        #1;
        chk("rst_valid", addr_valid, 0);
        chk("rst_data", addr_data, 0);
        chk("rst_last", addr_last, 0);
        chk("rst_idle", ap_idle, 1);
        chk("rst_done", ap_done, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        any_done = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge ap_clk);
            if (ap_done || addr_valid) any_done = 1;
        end
        chk("no_done_after_reset", any_done, 0);
        v = '{4, 4, 1, 0, 16, 15, 1};
        run_job(v);
    endtask

    initial begin
        exp44 = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
        exp55 = '{0, 1, 5, 6, 2, 3, 7, 8, 10, 11, 15, 16, 12, 13, 17, 18};
        tbl[0] = '{4, 4, 1, 0, 16, 15, 1};
        tbl[1] = '{5, 5, 1, 0, 16, 18, 1};
        tbl[2] = '{4, 4, 1, 1, 16, 15, 0};
        tbl[3] = '{30, 30, 2, 0, 1800, 1799, 1};
        tbl[4] = '{1, 4, 3, 0, 0, 0, 0};
        tbl[5] = '{3, 3, 2, 0, 8, 13, 1};
        tbl[6] = '{2, 6, 1, 1, 12, 11, 0};
        tbl[7] = '{4, 4, 0, 0, 0, 0, 0};

        ap_rst = 1'b1; ap_start = 1'b0; addr_ready = 1'b1;
        cfg_width = '0; cfg_height = '0; cfg_chan = '0;
        repeat (2) @(negedge ap_clk);
        chk("reset_valid", addr_valid, 0);
        chk("reset_data", addr_data, 0);
        chk("reset_idle", ap_idle, 1);
        chk("reset_done", ap_done, 0);
        chk("reset_ready", ap_ready, 0);
        ap_rst = 1'b0;

        for (int i = 0; i < 8; i++) run_job(tbl[i]);
        reset_mid_job();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
